convert_from_fp: RTL and testbench
==================================

// Module: convert_from_fp
// PURPOSE
// - Inverse of the lattice integer->fixed-point converter. Takes signed two's-complement fixed-point
//   results from the LBM collision/stream datapath and returns saturated unsigned integers.
// - Outputs go to the cell-state/display path, e.g. 8-bit density for VGA shading.
// - Two-stage valid/ready pipeline: stage 1 rounds, stage 2 saturates. Backpressure stalls both stages.
// PARAMETERS
// - INPUT_WIDTH  32  width of fixed-point Data_In (signed two's complement)
// - OUTPUT_WIDTH 8   width of unsigned integer Data_Out; must satisfy OUTPUT_WIDTH <= INPUT_WIDTH-FBITS
// - FBITS        24  fractional bits in Data_In; must satisfy 1 <= FBITS < INPUT_WIDTH
// PORTS
// - Clk       in   1             single clock, rising edge
// - Reset     in   1             asynchronous, active-high
// - In_Valid  in   1             Data_In holds a valid sample
// - In_Ready  out  1             block accepts Data_In this cycle
// - Data_In   in   INPUT_WIDTH   fixed-point sample (Q(INPUT_WIDTH-FBITS).FBITS)
// - Out_Valid out  1             Data_Out/Sat are valid
// - Out_Ready in   1             downstream accepts Data_Out this cycle
// - Data_Out  out  OUTPUT_WIDTH  converted unsigned integer
// - Sat       out  1             1 = Data_Out was clamped (negative or overflow); qualified by Out_Valid
// BEHAVIOUR
// - Reset, async, active-high: S1_Valid, Out_Valid, Data_Out and Sat clear to 0, and the S1 data register clears.
//   Any samples in flight are discarded. In_Ready reads 1 the first cycle after Reset deasserts.
// - Transfers: input on In_Valid&&In_Ready; output on Out_Valid&&Out_Ready.
// - Pipeline control:
//   - Adv2 = !Out_Valid || Out_Ready
//   - Adv1 = !S1_Valid || Adv2
//   - In_Ready = Adv1 (combinational; no path from In_Valid to In_Ready)
// - Stage 1 (when Adv1): S1_Valid <= In_Valid.
//   - S1_Sum is INPUT_WIDTH+1 bits, sign-extended.
//   - Round: S1_Sum <= sext(Data_In) + (1<<(FBITS-1)), i.e. round half up toward +inf.
//   - No round: S1_Sum <= sext(Data_In).
// - Stage 2 (when Adv2): Out_Valid <= S1_Valid.
//   - Int = S1_Sum >>> FBITS (arithmetic shift).
//   - Int < 0: Data_Out <= 0, Sat <= 1.
//   - Int > 2^OUTPUT_WIDTH-1: Data_Out <= all ones, Sat <= 1.
//   - Otherwise: Data_Out <= Int[OUTPUT_WIDTH-1:0], Sat <= 0.
// - Latency is 2 cycles from input transfer to Out_Valid when Out_Ready is held 1. Throughput is 1 sample/clk.
// - Stall: Out_Valid&&!Out_Ready holds Data_Out/Sat stable. S1 still fills if it is empty; In_Ready drops only when both stages are full.
// - Simultaneous input and output transfer with a full pipe is allowed: both stages shift in one cycle with no bubble.
// - Data_Out/Sat are undefined-but-stable when Out_Valid=0. No sample is dropped or duplicated.
// - Rounding never wraps, thanks to the +1 guard bit: max positive input rounds to 2^(INPUT_WIDTH-FBITS-1).
// CONFIGURATION
// - Macro CONVERT_FROM_FP_ROUND_EN.
// - Defined: round-half-up as above.
// - Undefined: stage 1 adds nothing, so the result truncates toward -inf (floor).
// - Ports and latency are identical in both builds.
// STRUCTURE
// - Package lbm_fp_pkg holds:
//   - FP_WIDTH=32, FP_FBITS=24, CELL_WIDTH=8 constants, shared with convert_to_fp.
//   - typedef logic signed [FP_WIDTH-1:0] fp_t.
//   - typedef logic [CELL_WIDTH-1:0] cell_t.
// - The module body is self-contained; stage control and datapath live together in one module.
// - One natural sub-module: fp_saturate, the combinational stage-2 clamp (Int -> Data_Out, Sat).
//   It is reused wherever the datapath narrows fixed-point.
// TESTING (defaults unless noted; Out_Ready=1 unless noted)
// - Data_In=32'h0A00_0000 (10.0) -> 2 clks later Data_Out=8'd10, Sat=0.
// - Data_In=32'h0A80_0000 (10.5): ROUND_EN -> 11; without -> 10.
//   Data_In=32'h7FFF_FFFF: ROUND_EN -> 128; without -> 127. Sat=0 in all four cases.
// - Data_In=32'hFF00_0000 (-1.0) -> Data_Out=0, Sat=1.
//   OUTPUT_WIDTH=4, Data_In=32'h1000_0000 (16.0) -> 4'hF, Sat=1.
// - Stream of 8 values 1..8 with Out_Ready low for cycles 3-6:
//   -> In_Ready=0 once two samples are held; output order 1..8 with no loss or duplicates;
//   -> Data_Out held stable while stalled.
// - Assert Reset mid-stream with both stages full -> Out_Valid=0, Data_Out=0, Sat=0 immediately;
//   -> after release, the first new input appears 2 clks after acceptance and no stale sample is emitted.

Source files
------------

// File: rtl/lbm_fp_pkg.sv
// Shared lattice fixed-point constants and types.
// Used by convert_to_fp and convert_from_fp.
package lbm_fp_pkg;

    localparam int FP_WIDTH   = 32;
    localparam int FP_FBITS   = 24;
    localparam int CELL_WIDTH = 8;

    typedef logic signed [FP_WIDTH-1:0] fp_t;
    typedef logic [CELL_WIDTH-1:0]      cell_t;

endpackage

// File: rtl/fp_saturate.sv
// Combinational clamp: shifted fixed-point sum -> unsigned integer.
// Negative values clamp to 0, values above range clamp to all ones.
module fp_saturate #(
    parameter int SUM_WIDTH = 33,
    parameter int FBITS     = 24,
    parameter int OUT_WIDTH = 8
) (
    input  logic signed [SUM_WIDTH-1:0] sum,
    output logic [OUT_WIDTH-1:0]        value,
    output logic                        sat
);

    logic signed [SUM_WIDTH-1:0] int_v;
    logic                        neg;
    logic                        ovf;

    assign int_v = sum >>> FBITS;
    assign neg   = int_v[SUM_WIDTH-1];
    // Any set bit above the output range means overflow (once non-negative).
    assign ovf   = |(int_v >> OUT_WIDTH);

    always_comb begin
        value = int_v[OUT_WIDTH-1:0];
        sat   = 1'b0;
        unique case (1'b1)
            neg: begin
                value = '0;
                sat   = 1'b1;
            end
            !neg && ovf: begin
                value = '1;
                sat   = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/convert_from_fp.sv
// Two-stage fixed-point -> saturated unsigned integer converter.
// Define CONVERT_FROM_FP_ROUND_EN for round-half-up; otherwise floor.
module convert_from_fp
    import lbm_fp_pkg::*;
#(
    parameter int INPUT_WIDTH  = FP_WIDTH,
    parameter int OUTPUT_WIDTH = CELL_WIDTH,
    parameter int FBITS        = FP_FBITS
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          In_Valid,
    output logic                          In_Ready,
    input  logic signed [INPUT_WIDTH-1:0] Data_In,
    output logic                          Out_Valid,
    input  logic                          Out_Ready,
    output logic [OUTPUT_WIDTH-1:0]       Data_Out,
    output logic                          Sat
);

    localparam int SW = INPUT_WIDTH + 1;

`ifdef CONVERT_FROM_FP_ROUND_EN
    localparam logic signed [SW-1:0] RND =
        {{(SW-1){1'b0}}, 1'b1} << (FBITS - 1);
`else
    localparam logic signed [SW-1:0] RND = '0;
`endif

    logic                    s1_valid;
    logic signed [SW-1:0]    s1_sum;
    logic signed [SW-1:0]    sum_d;
    logic                    adv1;
    logic                    adv2;
    logic [OUTPUT_WIDTH-1:0] sat_value;
    logic                    sat_flag;

    assign adv2     = !Out_Valid || Out_Ready;
    assign adv1     = !s1_valid || adv2;
    assign In_Ready = adv1;

    // The guard bit keeps max-positive + half from wrapping.
    assign sum_d = {Data_In[INPUT_WIDTH-1], Data_In} + RND;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_sum   <= '0;
        end else if (adv1) begin
            s1_valid <= In_Valid;
            if (In_Valid) begin
                s1_sum <= sum_d;
            end
        end
    end

    fp_saturate #(
        .SUM_WIDTH (SW),
        .FBITS     (FBITS),
        .OUT_WIDTH (OUTPUT_WIDTH)
    ) u_sat (
        .sum   (s1_sum),
        .value (sat_value),
        .sat   (sat_flag)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Out_Valid <= 1'b0;
            Data_Out  <= '0;
            Sat       <= 1'b0;
        end else if (adv2) begin
            Out_Valid <= s1_valid;
            if (s1_valid) begin
                Data_Out <= sat_value;
                Sat      <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_convert_from_fp.sv
// Directed bench for convert_from_fp (8-bit and 4-bit output builds).
module tb_convert_from_fp;

`ifdef CONVERT_FROM_FP_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        In_Valid = 1'b0;
    logic        Out_Ready = 1'b1;
    logic [31:0] Data_In = '0;

    logic        In_Ready, Out_Valid, Sat;
    logic [7:0]  Data_Out;
    logic        In_Ready4, Out_Valid4, Sat4;
    logic [3:0]  Data_Out4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    convert_from_fp u_dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Data_In   (Data_In),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Data_Out  (Data_Out),
        .Sat       (Sat)
    );

    convert_from_fp #(.OUTPUT_WIDTH(4)) u_dut4 (
        .Clk       (Clk),
        .Reset     (Reset),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready4),
        .Data_In   (Data_In),
        .Out_Valid (Out_Valid4),
        .Out_Ready (Out_Ready),
        .Data_Out  (Data_Out4),
        .Sat       (Sat4)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with an empty pipe and Out_Ready=1.
    task automatic single(input string tag, input logic [31:0] d,
                          input logic [7:0] e8, input logic s8,
                          input logic [3:0] e4, input logic s4);
        check({tag, "_rdy"}, 32'(In_Ready), 32'd1);
        In_Valid = 1'b1;
        Data_In  = d;
        @(posedge Clk);
        @(negedge Clk);
        In_Valid = 1'b0;
        check({tag, "_lat1"}, 32'(Out_Valid), 32'd0);
        @(negedge Clk);
        check({tag, "_vld"}, 32'(Out_Valid), 32'd1);
        check({tag, "_d8"}, 32'(Data_Out), 32'(e8));
        check({tag, "_s8"}, 32'(Sat), 32'(s8));
        check({tag, "_d4"}, 32'(Data_Out4), 32'(e4));
        check({tag, "_s4"}, 32'(Sat4), 32'(s4));
    endtask

    initial begin
        int         sent;
        int         got;
        bit         stalled;
        bit         saw_low;
        bit         in_fire;
        logic [7:0] held;

        repeat (2) @(negedge Clk);
        check("rst_vld", 32'(Out_Valid), 32'd0);
        check("rst_data", 32'(Data_Out), 32'd0);
        check("rst_sat", 32'(Sat), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        single("v10", 32'h0A00_0000, 8'd10, 1'b0, 4'hA, 1'b0);
        single("v10p5", 32'h0A80_0000, RND ? 8'd11 : 8'd10, 1'b0,
               RND ? 4'hB : 4'hA, 1'b0);
        single("vmax", 32'h7FFF_FFFF, RND ? 8'd128 : 8'd127, 1'b0,
               4'hF, 1'b1);
        single("vneg1", 32'hFF00_0000, 8'd0, 1'b1, 4'h0, 1'b1);
        single("vnegh", 32'hFF80_0000, 8'd0, !RND, 4'h0, !RND);
        single("v16", 32'h1000_0000, 8'd16, 1'b0, 4'hF, 1'b1);
        single("vfrac", 32'h00FF_FFFF, RND ? 8'd1 : 8'd0, 1'b0,
               RND ? 4'h1 : 4'h0, 1'b0);
        @(negedge Clk);

        sent    = 0;
        got     = 0;
        stalled = 1'b0;
        saw_low = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            Out_Ready = !(cyc >= 3 && cyc <= 6);
            In_Valid  = (sent < 8);
            Data_In   = 32'(sent + 1) << 24;
            #1;
            if (!In_Ready) saw_low = 1'b1;
            if (Out_Valid && stalled)
                check("hold", 32'(Data_Out), 32'(held));
            if (Out_Valid && Out_Ready) begin
                check("order", 32'(Data_Out), 32'(got + 1));
                got++;
            end
            stalled = Out_Valid && !Out_Ready;
            held    = Data_Out;
            in_fire = In_Valid && In_Ready;
            @(posedge Clk);
            if (in_fire) sent++;
            @(negedge Clk);
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        check("strm_got", 32'(got), 32'd8);
        check("strm_sent", 32'(sent), 32'd8);
        check("strm_rdy_low", 32'(saw_low), 32'd1);
        check("strm_drain", 32'(Out_Valid), 32'd0);

        Out_Ready = 1'b0;
        In_Valid  = 1'b1;
        Data_In   = 32'h1400_0000;
        @(posedge Clk);
        @(negedge Clk);
        Data_In = 32'h1500_0000;
        @(posedge Clk);
        @(negedge Clk);
        In_Valid = 1'b0;
        #1;
        check("full_rdy", 32'(In_Ready), 32'd0);
        check("full_vld", 32'(Out_Valid), 32'd1);
        Reset = 1'b1;
        #1;
        check("mrst_vld", 32'(Out_Valid), 32'd0);
        check("mrst_data", 32'(Data_Out), 32'd0);
        check("mrst_sat", 32'(Sat), 32'd0);
        @(negedge Clk);
        Reset     = 1'b0;
        Out_Ready = 1'b1;
        @(negedge Clk);
        check("stale", 32'(Out_Valid), 32'd0);
        single("post", 32'h0500_0000, 8'd5, 1'b0, 4'h5, 1'b0);
        @(negedge Clk);
        check("post_drain", 32'(Out_Valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
